// File: rtl/mem_seq_pkg.sv
// Shared types for the load/store byte sequencer.
// State encoding, size encoding and default word geometry.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FINISH,
    DONE
  } state_e;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  localparam int NBYTES = 4;

endpackage

// File: rtl/mem_byte_sequencer.sv
// Splits word loads/stores into little-endian byte RAM accesses.
// Optional macro MEM_BYTE_SEQ_ALIGN_CHECK_EN rejects unaligned words.
module mem_byte_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last;

  logic              we_q;
  logic              size_q;
  logic              mis_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] aout_q;
  logic [7:0]        bout_q;

  logic              xfer;
  logic              misal;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_byte;

`ifdef MEM_BYTE_SEQ_ALIGN_CHECK_EN
  assign misal = (size == SZ_WORD) && (addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign xfer     = (state_q == XFER);
  assign last     = (size_q == SZ_WORD) ? CW'(NB - 1) : '0;
  assign cur_addr = addr_q + ADDR_W'(cnt_q);
  assign cur_byte = wdata_q[8*cnt_q +: 8];

  assign ram_addr  = xfer ? cur_addr : aout_q;
  assign ram_wdata = xfer ? cur_byte : bout_q;
  assign ram_we    = xfer & we_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = done & mis_q;
  assign rdata     = rdata_q;

  // State and byte counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one XFER cycle per byte, then FINISH and DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = '0;
          state_d = misal ? DONE : XFER;
        end
      end
      XFER: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last) state_d = FINISH;
      end
      FINISH:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, held RAM outputs and load byte reassembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aout_q  <= '0;
      bout_q  <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        we_q    <= we;
        size_q  <= size;
        mis_q   <= misal;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (xfer) begin
        aout_q <= cur_addr;
        bout_q <= cur_byte;
      end
      if (xfer && !we_q && cnt_q != '0) begin
        rdata_q[8*(int'(cnt_q)-1) +: 8] <= ram_rdata;
      end
      if (state_q == FINISH && !we_q) begin
        if (size_q == SZ_BYTE) rdata_q <= DATA_W'(ram_rdata);
        else rdata_q[8*(NB-1) +: 8] <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a 256-byte sync RAM model.
// Define MEM_BYTE_SEQ_ALIGN_CHECK_EN to check the alignment variant.
module tb_mem_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        size = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = '0;
  logic        clr = 1'b1;

  logic [7:0] mem [256];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_byte_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk),
    .reset(rst_n),
    .req(req),
    .we(we),
    .size(size),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy),
    .done(done),
    .err(err),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  // Byte RAM with one-cycle registered read
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic w, input logic s,
                        input logic [7:0] a, input logic [31:0] d,
                        output int lat, output int wec,
                        output logic e);
    we = w;
    size = s;
    addr = a;
    wdata = d;
    req = 1'b1;
    lat = -1;
    wec = 0;
    e = 1'b0;
    if (ram_we) wec++;
    step();
    req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ram_we) wec++;
      if (done) begin
        lat = c;
        e = err;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    total++;
    if ({rdata, ram_addr, ram_wdata} !== 48'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h want=0", rdata, ram_addr, ram_wdata);
    end
    total++;
    if ({busy, done, err, ram_we} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0000", {busy, done, err, ram_we});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_word_store();
    int lat, wec;
    logic e;
    access(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, lat, wec, e);
    total++;
    if (lat !== 6) begin
      bad++;
      $display("FAIL wst_latency got=%0d want=6", lat);
    end
    total++;
    if (wec !== 4) begin
      bad++;
      $display("FAIL wst_we_cycles got=%0d want=4", wec);
    end
    total++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hEFBEADDE) begin
      bad++;
      $display("FAIL wst_ram got=%h %h %h %h want=ef be ad de",
               mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]);
    end
    total++;
    if (busy !== 1'b0 || e !== 1'b0) begin
      bad++;
      $display("FAIL wst_busy_err got=%b%b want=00", busy, e);
    end
  endtask

  task automatic test_word_load();
    int lat, wec;
    logic e;
    access(1'b0, 1'b1, 8'h10, 32'h0, lat, wec, e);
    total++;
    if (lat !== 6) begin
      bad++;
      $display("FAIL wld_latency got=%0d want=6", lat);
    end
    total++;
    if (wec !== 0) begin
      bad++;
      $display("FAIL wld_we_cycles got=%0d want=0", wec);
    end
    total++;
    if (rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wld_rdata got=%h want=deadbeef", rdata);
    end
  endtask

  task automatic test_byte();
    int lat, wec;
    logic e;
    access(1'b0, 1'b0, 8'h12, 32'h0, lat, wec, e);
    total++;
    if (lat !== 3 || rdata !== 32'h000000AD) begin
      bad++;
      $display("FAIL bld got lat=%0d rdata=%h want lat=3 rdata=000000ad", lat, rdata);
    end
    access(1'b1, 1'b0, 8'h13, 32'h0000005A, lat, wec, e);
    total++;
    if (lat !== 3 || wec !== 1 || mem[8'h13] !== 8'h5A) begin
      bad++;
      $display("FAIL bst got lat=%0d we=%0d ram=%h want 3/1/5a", lat, wec, mem[8'h13]);
    end
    total++;
    if (mem[8'h12] !== 8'hAD || mem[8'h14] !== 8'h00) begin
      bad++;
      $display("FAIL bst_neighbors got=%h %h want=ad 00", mem[8'h12], mem[8'h14]);
    end
    access(1'b0, 1'b1, 8'h10, 32'h0, lat, wec, e);
    total++;
    if (rdata !== 32'h5AADBEEF) begin
      bad++;
      $display("FAIL mixed_wld got=%h want=5aadbeef", rdata);
    end
  endtask

  task automatic test_wrap();
    int lat, wec;
    logic e;
    access(1'b1, 1'b1, 8'hFE, 32'h11223344, lat, wec, e);
`ifdef MEM_BYTE_SEQ_ALIGN_CHECK_EN
    total++;
    if (lat !== 1 || e !== 1'b1 || wec !== 0) begin
      bad++;
      $display("FAIL unaligned got lat=%0d err=%b we=%0d want 1/1/0", lat, e, wec);
    end
    total++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'h0) begin
      bad++;
      $display("FAIL unaligned_ram got=%h %h %h %h want=0",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
`else
    total++;
    if (lat !== 6 || e !== 1'b0 || wec !== 4) begin
      bad++;
      $display("FAIL wrap got lat=%0d err=%b we=%0d want 6/0/4", lat, e, wec);
    end
    total++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'h44332211) begin
      bad++;
      $display("FAIL wrap_ram got=%h %h %h %h want=44 33 22 11",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
`endif
    total++;
    if (rdata !== 32'h5AADBEEF) begin
      bad++;
      $display("FAIL store_keeps_rdata got=%h want=5aadbeef", rdata);
    end
  endtask

  task automatic test_reset_mid();
    int lat, wec;
    logic e;
    we = 1'b1;
    size = 1'b1;
    addr = 8'h20;
    wdata = 32'hA1B2C3D4;
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h22) begin
      bad++;
      $display("FAIL mid_third_byte got we=%b addr=%h want 1/22", ram_we, ram_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rdata, ram_addr, ram_wdata, busy, done, err, ram_we} !== 52'h0) begin
      bad++;
      $display("FAIL mid_reset_outs got rd=%h a=%h wd=%h ctl=%b want 0",
               rdata, ram_addr, ram_wdata, {busy, done, err, ram_we});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    total++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'hD4C30000) begin
      bad++;
      $display("FAIL mid_ram got=%h %h %h %h want=d4 c3 00 00",
               mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]);
    end
    access(1'b0, 1'b1, 8'h20, 32'h0, lat, wec, e);
    total++;
    if (lat !== 6 || rdata !== 32'h0000C3D4) begin
      bad++;
      $display("FAIL mid_restart got lat=%0d rdata=%h want 6/0000c3d4", lat, rdata);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int first;
    int second;
    ndone = 0;
    first = -1;
    second = -1;
    we = 1'b1;
    size = 1'b1;
    addr = 8'h30;
    wdata = 32'h01020304;
    req = 1'b1;
    step();
    addr = 8'h40;
    wdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 13; c++) begin
      if (done) begin
        ndone++;
        if (first < 0) first = c;
        else second = c;
      end
      if (c == 13) req = 1'b0;
      step();
    end
    for (int c = 0; c < 10; c++) begin
      if (done) ndone++;
      step();
    end
    total++;
    if (ndone !== 2 || first !== 6 || second !== 13) begin
      bad++;
      $display("FAIL b2b_dones got n=%0d at %0d,%0d want 2 at 6,13", ndone, first, second);
    end
    total++;
    if ({mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]} !== 32'h04030201) begin
      bad++;
      $display("FAIL b2b_first_ram got=%h %h %h %h want=04 03 02 01",
               mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]);
    end
    total++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL b2b_second_ram got=%h %h %h %h want=ff ff ff ff",
               mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_word_load();
    test_byte();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
